ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hF4 enable) to the keyboard.

---
 rtl/ps2_host_tx_pkg.sv | 41 ++++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter and its keyboard receiver neighbour:
// FSM encoding, command/response bytes and the frame bit helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6,
    ST_WAIT_IDLE = 3'd7
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  localparam logic [3:0] BIT_PARITY  = 4'd9;
  localparam logic [3:0] BIT_STOP    = 4'd10;

  // Pull-low enable for frame slot n (1..8 data LSB first, 9 parity, 10 stop).
  function automatic logic frame_pull(input logic [7:0] data,
                                      input logic       parity,
                                      input logic [3:0] n);
    logic [2:0] idx;
    logic       pull;
    idx  = n[2:0] - 3'd1;
    pull = 1'b0;
    if ((n >= 4'd1) && (n <= 4'd8)) begin
      pull = ~data[idx];
    end else if (n == BIT_PARITY) begin
      pull = ~parity;
    end
    return pull;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS2_CLK/PS2_DATA pins plus a one-cycle PS2_CLK falling-edge strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic clk_pin_i,
  input  logic data_pin_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_meta_q;
  logic [1:0] data_meta_q;
  logic       clk_prev_q;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], clk_pin_i};
      data_meta_q <= {data_meta_q[0], data_pin_i};
      clk_prev_q  <= clk_meta_q[1];
    end
  end

  assign clk_sync_o  = clk_meta_q[1];
  assign data_sync_o = data_meta_q[1];
  assign clk_fall_o  = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-collector pull-low enables.
// Flow: IDLE -> INHIBIT -> RTS -> DATA -> ACK -> DONE|ERR -> WAIT_IDLE -> IDLE (timeout aborts to IDLE).
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic [3:0]       bit_q, bit_d;
  logic [3:0]       bit_nxt;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             timeout;
  logic             accept;

  logic sync_clk;
  logic sync_data;
  logic clk_fall;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .clk_pin_i   (ps2_clk_in),
    .data_pin_i  (ps2_data_in),
    .clk_sync_o  (sync_clk),
    .data_sync_o (sync_data),
    .clk_fall_o  (clk_fall)
  );

  assign tx_ready = (state_q == ST_IDLE);
  assign accept   = tx_valid & tx_ready;
  assign bit_nxt  = bit_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    par_d     = par_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    to_d      = to_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    timeout   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (accept) begin
          byte_d   = tx_data;
          par_d    = ~^tx_data;
          inh_d    = INH_LOAD;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_q == '0) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          bit_d     = 4'd0;
          to_d      = TO_LOAD;
          state_d   = ST_RTS;
        end else begin
          inh_d = inh_q - 1'b1;
        end
      end

      ST_RTS, ST_DATA, ST_ACK: begin
        // A device clock edge always beats an expiring timeout on the same cycle.
        if (clk_fall) begin
          to_d = TO_LOAD;
          if (state_q == ST_ACK) begin
            state_d = sync_data ? ST_ERR : ST_DONE;
          end else begin
            bit_d     = bit_nxt;
            data_oe_d = frame_pull(byte_q, par_q, bit_nxt);
            state_d   = (bit_nxt == BIT_STOP) ? ST_ACK : ST_DATA;
          end
        end else if (to_q != '0) begin
          to_d = to_q - 1'b1;
        end else begin
          timeout   = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      ST_DONE, ST_ERR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_WAIT_IDLE;
      end

      ST_WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      byte_q    <= 8'h00;
      par_q     <= 1'b0;
      bit_q     <= 4'd0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = ~tx_ready | accept;
  assign tx_done     = (state_q == ST_DONE);
  assign tx_error    = (state_q == ST_ERR) | timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model clocking at a 40-cycle period.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: measures inhibit, reads start bit, then clocks n_falls times; data read at end of low phase.
  task automatic bfm_frame(input int n_falls, input bit ack_low, output logic [10:0] bits,
                           output int inh_len, output bit to, output int last_fall);
    int g;
    bits = '1; inh_len = 0; to = 1'b0; last_fall = 0; g = 0;
    while (ps2_clk_oe !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    if (ps2_clk_oe !== 1'b1) begin to = 1'b1; return; end
    while (ps2_clk_oe === 1'b1 && inh_len < 200) begin @(negedge clk); inh_len++; end
    bits[0] = ps2_data_in;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 11 && ack_low) begin
        dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (20) @(negedge clk);
      if (i <= 10) bits[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_bad++; $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    n_cmp++; if ({tx_ready, busy, tx_done, tx_error} !== 4'b1000) begin n_bad++; $display("FAIL reset_flags: got %b want 1000", {tx_ready, busy, tx_done, tx_error}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int g, d0, e0;
    send(CMD_ENABLE);
    g = 0;
    while (ps2_data_oe !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    n_cmp++; if (ps2_data_oe !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_rts: got %b want 1", ps2_data_oe); end
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_bad++; $display("FAIL midrst_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    n_cmp++; if ({tx_ready, busy, tx_done, tx_error} !== 4'b1000) begin n_bad++; $display("FAIL midrst_flags: got %b want 1000", {tx_ready, busy, tx_done, tx_error}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin n_bad++; $display("FAIL midrst_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_send_led();
    logic [10:0] bits; int inh, lf, d0, e0; bit to;
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_SET_LED);
    n_cmp++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin n_bad++; $display("FAIL led_busy: got busy %b ready %b want 1 0", busy, tx_ready); end
    bfm_frame(11, 1'b1, bits, inh, to, lf);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL led_bfm_wait: got %b want 0", to); end
    n_cmp++; if (inh !== INH) begin n_bad++; $display("FAIL led_inhibit: got %0d want %0d", inh, INH); end
    n_cmp++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin n_bad++; $display("FAIL led_frame: got %h want %h", bits, {1'b1, 1'b1, 8'hED, 1'b0}); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL led_wait_idle: got %b want 0", tx_ready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL led_ready_early: got %b want 0", tx_ready); end
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL led_ready: got ready %b busy %b want 1 0", tx_ready, busy); end
    n_cmp++; if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin n_bad++; $display("FAIL led_pulses: got done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_parity();
    logic [10:0] bits, exp; logic [7:0] b; int inh, lf, d0, g; bit to;
    for (int i = 0; i < 2; i++) begin
      b   = (i == 0) ? 8'h00 : 8'h07;
      exp = (i == 0) ? {1'b1, 1'b1, 8'h00, 1'b0} : {1'b1, 1'b0, 8'h07, 1'b0};
      d0 = done_cnt;
      send(b);
      bfm_frame(11, 1'b1, bits, inh, to, lf);
      g = 0;
      while (tx_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      n_cmp++; if (bits !== exp) begin n_bad++; $display("FAIL parity_frame[%0d]: got %h want %h", i, bits, exp); end
      n_cmp++; if ((done_cnt - d0) !== 1 || tx_ready !== 1'b1) begin n_bad++; $display("FAIL parity_done[%0d]: got done %0d ready %b want 1 1", i, done_cnt - d0, tx_ready); end
    end
  endtask

  task automatic test_nack();
    logic [10:0] bits; int inh, lf, d0, e0, g; bit to;
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_ENABLE);
    bfm_frame(11, 1'b0, bits, inh, to, lf);
    g = 0;
    while (tx_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    n_cmp++; if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin n_bad++; $display("FAIL nack_frame: got %h want %h", bits, {1'b1, 1'b0, 8'hF4, 1'b0}); end
    n_cmp++; if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin n_bad++; $display("FAIL nack_pulses: got err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); end
    n_cmp++; if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin n_bad++; $display("FAIL nack_idle: got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_timeout();
    logic [10:0] bits; int inh, lf, d0, e0, g; bit to;
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_RESET);
    bfm_frame(3, 1'b0, bits, inh, to, lf);
    g = 0;
    while (tx_ready !== 1'b1 && g < 700) begin @(negedge clk); g++; end
    n_cmp++; if (bits[3:0] !== 4'b1110) begin n_bad++; $display("FAIL timeout_bits: got %b want 1110", bits[3:0]); end
    n_cmp++; if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin n_bad++; $display("FAIL timeout_pulses: got err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); end
    // Fall strobe lands two cycles after the pin drop (synchroniser depth).
    n_cmp++; if (err_cyc !== lf + 2 + TMO) begin n_bad++; $display("FAIL timeout_cycle: got %0d want %0d", err_cyc, lf + 2 + TMO); end
    n_cmp++; if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin n_bad++; $display("FAIL timeout_idle: got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits; int inh, lf, d0, g; bit to;
    d0 = done_cnt;
    send(CMD_SET_LED);
    tx_data  = CMD_ENABLE;
    tx_valid = 1'b1;
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored: got ready %b want 0", tx_ready); end
    bfm_frame(11, 1'b1, bits, inh, to, lf);
    n_cmp++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin n_bad++; $display("FAIL b2b_first: got %h want %h", bits, {1'b1, 1'b1, 8'hED, 1'b0}); end
    g = 0;
    while (tx_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
    @(negedge clk);
    tx_valid = 1'b0;
    n_cmp++; if (tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin n_bad++; $display("FAIL b2b_accepted: got ready %b clk_oe %b want 0 1", tx_ready, ps2_clk_oe); end
    bfm_frame(11, 1'b1, bits, inh, to, lf);
    n_cmp++; if (inh !== INH) begin n_bad++; $display("FAIL b2b_inhibit: got %0d want %0d", inh, INH); end
    n_cmp++; if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin n_bad++; $display("FAIL b2b_second: got %h want %h", bits, {1'b1, 1'b0, 8'hF4, 1'b0}); end
    g = 0;
    while (tx_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    repeat (5) @(negedge clk);
    n_cmp++; if ((done_cnt - d0) !== 2 || ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got done %0d clk_oe %b want 2 0", done_cnt - d0, ps2_clk_oe); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_send_led();
    test_parity();
    test_nack();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
